// File: rtl/shift_op_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_op_queue_pkg
// Description : Shared defaults for the shift-operation queue and the shifter
//               top level: operand/control widths, queue depth and the packed
//               {data, ctrl} operation record.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_op_queue_pkg;

  localparam int c_data_w = 8;   // operand / result width
  localparam int c_ctrl_w = 3;   // shift-amount width
  localparam int c_depth  = 4;   // FIFO entries (power of two, >= 2)

  // One queued operation; data occupies the upper bits, ctrl the lower bits.
  typedef struct packed {
    logic [c_data_w-1:0] data;
    logic [c_ctrl_w-1:0] ctrl;
  } op_t;

endpackage
`default_nettype wire

// File: rtl/shift_op_fifo.sv
`default_nettype none
// ============================================================================
// Module      : shift_op_fifo
// Description : Synchronous FIFO of packed operation entries with occupancy
//               level, full/empty flags and a combinational head read.
// Ports       : clk, rst_n          clock / async active-low reset
//               push, wr_data       write strobe (caller guarantees !full)
//               pop                 advance head (caller guarantees !empty)
//               head                entry at the read pointer
//               level, full, empty  occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module shift_op_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_full_lvl = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  // Storage carries no reset: contents are only observable through the
  // level-qualified head, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally in AW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign level = r_level;
  assign full  = (r_level == c_full_lvl);
  assign empty = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/shift_op_queue.sv
`default_nettype none
// ============================================================================
// Module      : shift_op_queue
// Description : Feeder and registered result stage for an external
//               combinational logical-right barrel shifter. Operations are
//               queued, the head entry drives the shifter, and the shifter
//               output is captured into a valid/ready result register.
// Ports       : clk, rst_n                 clock / async active-low reset
//               s_valid, s_ready,
//               s_data, s_ctrl             upstream operation handshake
//               shf_in, shf_ctrl           to shifter (0 when queue empty)
//               shf_out                    from shifter
//               m_valid, m_ready,
//               m_data, m_ctrl             downstream result handshake
//               level                      FIFO occupancy (excl. result reg)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_op_queue
  import shift_op_queue_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int CTRL_W = c_ctrl_w,
  parameter int DEPTH  = c_depth
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [CTRL_W-1:0]        s_ctrl,
  output logic [DATA_W-1:0]        shf_in,
  output logic [CTRL_W-1:0]        shf_ctrl,
  input  logic [DATA_W-1:0]        shf_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [CTRL_W-1:0]        m_ctrl,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int OP_W = DATA_W + CTRL_W;

  logic [OP_W-1:0]  w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_load;

  logic             r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;

  // s_ready depends on FIFO state only: a pop in the same cycle does not
  // free a slot for a push, which keeps m_ready off any path to s_ready.
  assign s_ready = !w_full;
  assign w_push  = s_valid && !w_full;
  assign w_load  = !w_empty && (!r_m_valid || m_ready);

  shift_op_fifo #(
    .WIDTH (OP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (w_push),
    .wr_data ({s_data, s_ctrl}),
    .pop     (w_load),
    .head    (w_head),
    .level   (level),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Present zeros to the shifter while empty so it never sees stale entries.
  assign shf_in   = w_empty ? '0 : w_head[OP_W-1:CTRL_W];
  assign shf_ctrl = w_empty ? '0 : w_head[CTRL_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_ctrl  <= '0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= shf_out;
      r_m_ctrl  <= w_head[CTRL_W-1:0];
    end else if (m_ready) begin
      // Result consumed with nothing queued behind it; data holds its value.
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_ctrl  = r_m_ctrl;

endmodule
`default_nettype wire
